// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU fetch/data ports, the arbiter and the shared memory.
// The slave modport is the arbiter; the master modport is everything around it.
interface mem_arbiter_if;
    logic        IReqF;
    logic [31:0] PCF;
    logic [31:0] InstrF;
    logic        IReadyF;
    logic        DReqM;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        DReadyM;
    logic        MemStall;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [31:0] MemRData;
    logic        MemAck;
    logic        MemErr;

    modport slave (
        input  IReqF, PCF, DReqM, MemWriteM, ALUOutM, WriteDataM, MemRData, MemAck,
        output InstrF, IReadyF, ReadDataM, DReadyM, MemStall,
               MemReq, MemWe, MemAddr, MemWData, MemErr
    );

    modport master (
        output IReqF, PCF, DReqM, MemWriteM, ALUOutM, WriteDataM, MemRData, MemAck,
        input  InstrF, IReadyF, ReadDataM, DReadyM, MemStall,
               MemReq, MemWe, MemAddr, MemWData, MemErr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between the fetch and data ports.
// Data wins ties; an access with no MemAck within TIMEOUT cycles is aborted.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DATA, FETCH} state_t;

    localparam logic [3:0] LastWait = 4'(TIMEOUT - 1);

    state_t     state, stateNext;
    logic [3:0] waitCnt;
    logic       grantD, grantI, ackDone, timedOut;

    always_comb begin
        stateNext = state;
        grantD    = 1'b0;
        grantI    = 1'b0;
        ackDone   = 1'b0;
        timedOut  = 1'b0;
        unique case (state)
            IDLE: begin
                // A port whose ready pulse is high is already served this cycle.
                if (bus.DReqM && !bus.DReadyM) begin
                    grantD    = 1'b1;
                    stateNext = DATA;
                end else if (bus.IReqF && !bus.IReadyF) begin
                    grantI    = 1'b1;
                    stateNext = FETCH;
                end
            end
            DATA, FETCH: begin
                if (bus.MemAck) begin
                    ackDone   = 1'b1;
                    stateNext = IDLE;
                end else if (waitCnt == LastWait) begin
                    timedOut  = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    assign bus.MemReq   = (state != IDLE);
    assign bus.MemStall = (bus.DReqM & ~bus.DReadyM) | (bus.IReqF & ~bus.IReadyF);

    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt       <= '0;
            bus.MemWe     <= 1'b0;
            bus.MemAddr   <= '0;
            bus.MemWData  <= '0;
            bus.InstrF    <= '0;
            bus.ReadDataM <= '0;
            bus.IReadyF   <= 1'b0;
            bus.DReadyM   <= 1'b0;
            bus.MemErr    <= 1'b0;
        end else begin
            bus.IReadyF <= 1'b0;
            bus.DReadyM <= 1'b0;

            if (grantD) begin
                waitCnt      <= '0;
                bus.MemAddr  <= bus.ALUOutM;
                bus.MemWe    <= bus.MemWriteM;
                bus.MemWData <= bus.WriteDataM;
            end else if (grantI) begin
                waitCnt      <= '0;
                bus.MemAddr  <= bus.PCF;
                bus.MemWe    <= 1'b0;
                bus.MemWData <= '0;
            end else if (state != IDLE && !bus.MemAck) begin
                waitCnt <= waitCnt + 4'd1;
            end

            // A requester that dropped its request before the ack gets no pulse.
            if (ackDone) begin
                if (state == DATA) begin
                    if (!bus.MemWe) bus.ReadDataM <= bus.MemRData;
                    bus.DReadyM <= bus.DReqM;
                end else begin
                    bus.InstrF  <= bus.MemRData;
                    bus.IReadyF <= bus.IReqF;
                end
            end

            if (timedOut) bus.MemErr <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed access table, hand-written
// priority/reset sequences, then randomized traffic against a transaction model.
module tb_mem_arbiter;
    localparam int unsigned TMO = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int nCmp = 0;
    int nBad = 0;

    typedef struct {
        bit          isData;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;       // wait cycles before the memory acks
        logic [31:0] rdata;
        int          expReady;  // cycle after request of the ready pulse, -1 = none
        int          expBusy;   // cycles MemReq is high
        logic [31:0] expData;   // ReadDataM (data port) or InstrF (fetch port) afterwards
        bit          expErr;
    } vec_t;

    typedef struct {
        logic        busy;
        logic        isData;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int unsigned age;
    } acc_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    task automatic clearInputs();
        bus.IReqF      = 1'b0;
        bus.PCF        = '0;
        bus.DReqM      = 1'b0;
        bus.MemWriteM  = 1'b0;
        bus.ALUOutM    = '0;
        bus.WriteDataM = '0;
        bus.MemRData   = '0;
        bus.MemAck     = 1'b0;
    endtask

    task automatic chkResetOuts(input string tag);
        chk({tag, ".MemReq"},    32'(bus.MemReq),  '0);
        chk({tag, ".MemWe"},     32'(bus.MemWe),   '0);
        chk({tag, ".IReadyF"},   32'(bus.IReadyF), '0);
        chk({tag, ".DReadyM"},   32'(bus.DReadyM), '0);
        chk({tag, ".MemErr"},    32'(bus.MemErr),  '0);
        chk({tag, ".InstrF"},    bus.InstrF,       '0);
        chk({tag, ".ReadDataM"}, bus.ReadDataM,    '0);
        chk({tag, ".MemAddr"},   bus.MemAddr,      '0);
        chk({tag, ".MemWData"},  bus.MemWData,     '0);
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        clearInputs();
        repeat (2) @(negedge clk);
        chkResetOuts("reset");
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rndAddr();
        logic [3:0] w;
        w = 4'($urandom_range(15));
        return {26'b0, w, 2'b00};
    endfunction

    // One isolated access; the memory acks after v.lat wait cycles.
    task automatic runEntry(input int idx, input vec_t v);
        int   readyAt = -1;
        int   busy = 0;
        int   waits = 0;
        int   nRdy = 0;
        logic prevErr, rdy, other;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        prevErr = bus.MemErr;
        if (v.isData) begin
            bus.DReqM = 1'b1; bus.MemWriteM = v.we; bus.ALUOutM = v.addr; bus.WriteDataM = v.wdata;
        end else begin
            bus.IReqF = 1'b1; bus.PCF = v.addr;
        end
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            bus.MemAck   = 1'b0;
            bus.MemRData = 32'hBAD0BAD0;
            if (bus.MemReq) begin
                busy++;
                chk({tag, ".MemAddr"}, bus.MemAddr, v.addr);
                chk({tag, ".MemWe"}, 32'(bus.MemWe), 32'(v.we));
                if (v.we) chk({tag, ".MemWData"}, bus.MemWData, v.wdata);
                if (waits == v.lat) begin
                    bus.MemAck   = 1'b1;
                    bus.MemRData = v.rdata;
                end
                waits++;
            end
            rdy   = v.isData ? bus.DReadyM : bus.IReadyF;
            other = v.isData ? bus.IReadyF : bus.DReadyM;
            chk({tag, ".otherReady"}, 32'(other), '0);
            if (rdy) begin
                nRdy++;
                if (readyAt < 0) readyAt = c;
            end
            if (rdy || (bus.MemErr && !prevErr)) begin
                bus.DReqM = 1'b0;
                bus.IReqF = 1'b0;
            end
            prevErr = bus.MemErr;
        end
        bus.MemAck = 1'b0;
        chk({tag, ".readyCycle"}, 32'(readyAt), 32'(v.expReady));
        chk({tag, ".readyCount"}, 32'(nRdy), (v.expReady < 0) ? 32'd0 : 32'd1);
        chk({tag, ".busyCycles"}, 32'(busy), 32'(v.expBusy));
        chk({tag, ".data"}, v.isData ? bus.ReadDataM : bus.InstrF, v.expData);
        chk({tag, ".MemErr"}, 32'(bus.MemErr), 32'(v.expErr));
        chk({tag, ".MemReqAfter"}, 32'(bus.MemReq), '0);
    endtask

    // Simultaneous requests; each requester keeps asserting through its ready cycle.
    task automatic seqPriority();
        int busy = 0, nD = 0, nI = 0, dAt = -1, iAt = -1;
        logic [31:0] a [2];
        a[0] = '0; a[1] = '0;
        @(negedge clk);
        bus.IReqF = 1'b1; bus.PCF = 32'h100;
        bus.DReqM = 1'b1; bus.MemWriteM = 1'b0; bus.ALUOutM = 32'h80;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.MemAck = 1'b0;
            if (bus.MemReq) begin
                if (busy == 0) chk("prio.firstWe", 32'(bus.MemWe), '0);
                if (busy < 2) a[busy] = bus.MemAddr;
                busy++;
                bus.MemAck   = 1'b1;
                bus.MemRData = bus.MemAddr ^ 32'hA5A50000;
            end
            if (bus.DReadyM) begin nD++; dAt = c; end
            if (bus.IReadyF) begin nI++; iAt = c; end
            if (dAt >= 0 && c > dAt) bus.DReqM = 1'b0;
            if (iAt >= 0 && c > iAt) bus.IReqF = 1'b0;
        end
        bus.MemAck = 1'b0;
        chk("prio.accesses", 32'(busy), 32'd2);
        chk("prio.firstAddr", a[0], 32'h80);
        chk("prio.secondAddr", a[1], 32'h100);
        chk("prio.dReadyCycle", 32'(dAt), 32'd2);
        chk("prio.iReadyCycle", 32'(iAt), 32'd4);
        chk("prio.dReadyCount", 32'(nD), 32'd1);
        chk("prio.iReadyCount", 32'(nI), 32'd1);
        chk("prio.ReadDataM", bus.ReadDataM, 32'hA5A50080);
        chk("prio.InstrF", bus.InstrF, 32'hA5A50100);
    endtask

    task automatic seqResetMidFetch();
        @(negedge clk);
        bus.IReqF = 1'b1; bus.PCF = 32'h44; bus.MemAck = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstMid.MemReqBefore", 32'(bus.MemReq), 32'd1);
        reset = 1'b1; bus.IReqF = 1'b0;
        bus.MemAck = 1'b1; bus.MemRData = 32'hFFFFFFFF;
        @(negedge clk);
        chkResetOuts("rstMid");
        reset = 1'b0; bus.MemAck = 1'b0;
        @(negedge clk);
        chk("rstMid.MemReqAfter", 32'(bus.MemReq), '0);
        chk("rstMid.IReadyF", 32'(bus.IReadyF), '0);
        bus.MemAck = 1'b1; bus.MemRData = 32'h12121212;
        @(negedge clk);
        chk("idleAck.MemReq", 32'(bus.MemReq), '0);
        chk("idleAck.IReadyF", 32'(bus.IReadyF), '0);
        chk("idleAck.InstrF", bus.InstrF, '0);
        bus.MemAck = 1'b0;
    endtask

    // Random requesters and memory latency against a transaction-level model.
    task automatic randomPhase(input int n);
        acc_t        m;
        logic        eI = 1'b0, eD = 1'b0, eErr = 1'b0, nI, nD;
        logic [31:0] eInstr = '0, eRData = '0;
        int          lat = 0, respAge = 0;
        logic [31:0] mem [16];
        foreach (mem[i]) mem[i] = $urandom;
        m = '{default: '0};
        for (int cyc = 0; cyc < n; cyc++) begin
            @(negedge clk);
            chk("rnd.MemReq", 32'(bus.MemReq), 32'(m.busy));
            if (m.busy) begin
                chk("rnd.MemAddr", bus.MemAddr, m.addr);
                chk("rnd.MemWe", 32'(bus.MemWe), 32'(m.we));
                if (m.we) chk("rnd.MemWData", bus.MemWData, m.wdata);
            end
            chk("rnd.IReadyF", 32'(bus.IReadyF), 32'(eI));
            chk("rnd.DReadyM", 32'(bus.DReadyM), 32'(eD));
            chk("rnd.InstrF", bus.InstrF, eInstr);
            chk("rnd.ReadDataM", bus.ReadDataM, eRData);
            chk("rnd.MemErr", 32'(bus.MemErr), 32'(eErr));

            if (bus.IReqF) begin
                if (eI) begin
                    if ($urandom_range(1) == 1) bus.PCF = rndAddr();
                    else bus.IReqF = 1'b0;
                end else if ($urandom_range(15) == 0) bus.IReqF = 1'b0;
            end else if ($urandom_range(2) == 0) begin
                bus.IReqF = 1'b1; bus.PCF = rndAddr();
            end
            if (bus.DReqM) begin
                if (eD) begin
                    if ($urandom_range(1) == 1) begin
                        bus.ALUOutM = rndAddr(); bus.MemWriteM = 1'($urandom_range(1));
                        bus.WriteDataM = $urandom;
                    end else bus.DReqM = 1'b0;
                end else if ($urandom_range(15) == 0) bus.DReqM = 1'b0;
            end else if ($urandom_range(2) == 0) begin
                bus.DReqM = 1'b1; bus.ALUOutM = rndAddr();
                bus.MemWriteM = 1'($urandom_range(1)); bus.WriteDataM = $urandom;
            end

            if (bus.MemReq) begin
                if (respAge == 0) lat = int'($urandom_range(5));
                bus.MemAck   = (respAge == lat);
                bus.MemRData = bus.MemAck ? mem[bus.MemAddr[5:2]] : $urandom;
                if (bus.MemAck && bus.MemWe) mem[bus.MemAddr[5:2]] = bus.MemWData;
                respAge++;
            end else begin
                respAge      = 0;
                bus.MemAck   = ($urandom_range(3) == 0);
                bus.MemRData = $urandom;
            end
            #1;
            chk("rnd.MemStall", 32'(bus.MemStall),
                32'((bus.DReqM & ~eD) | (bus.IReqF & ~eI)));

            nI = 1'b0; nD = 1'b0;
            if (m.busy) begin
                if (bus.MemAck) begin
                    if (m.isData) begin
                        if (!m.we) eRData = bus.MemRData;
                        nD = bus.DReqM;
                    end else begin
                        eInstr = bus.MemRData;
                        nI = bus.IReqF;
                    end
                    m.busy = 1'b0;
                end else if (m.age + 1 >= TMO) begin
                    m.busy = 1'b0;
                    eErr   = 1'b1;
                end else m.age++;
            end else if (bus.DReqM && !eD) begin
                m = '{busy: 1'b1, isData: 1'b1, addr: bus.ALUOutM, we: bus.MemWriteM,
                      wdata: bus.WriteDataM, age: 0};
            end else if (bus.IReqF && !eI) begin
                m = '{busy: 1'b1, isData: 1'b0, addr: bus.PCF, we: 1'b0, wdata: '0, age: 0};
            end
            eI = nI; eD = nD;
        end
        clearInputs();
    endtask

    initial begin
        vecs[0] = '{0, 0, 32'h10, 32'h0,        0, 32'hE2811001,  2, 1, 32'hE2811001, 0};
        vecs[1] = '{1, 0, 32'h80, 32'h0,        1, 32'hCAFEF00D,  3, 2, 32'hCAFEF00D, 0};
        vecs[2] = '{1, 1, 32'h40, 32'h12345678, 3, 32'hDEADBEEF,  5, 4, 32'hCAFEF00D, 0};
        vecs[3] = '{0, 0, 32'h24, 32'h0,        2, 32'h0BADC0DE,  4, 3, 32'h0BADC0DE, 0};
        vecs[4] = '{1, 0, 32'h00, 32'h0,        3, 32'h11112222,  5, 4, 32'h11112222, 0};
        vecs[5] = '{0, 0, 32'h30, 32'h0,        9, 32'h77777777, -1, 4, 32'h0BADC0DE, 1};
        vecs[6] = '{0, 0, 32'h14, 32'h0,        0, 32'h55AA55AA,  2, 1, 32'h55AA55AA, 1};

        reset = 1'b1;
        clearInputs();
        doReset();
        for (int i = 0; i < 7; i++) runEntry(i, vecs[i]);
        seqPriority();
        seqResetMidFetch();
        doReset();
        randomPhase(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, 15, max wait cycles for MemAck per access; legal range 1..15.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 IReqF  in  1  fetch-port request; held by requester until IReadyF.
REQ-005 PCF  in  32  fetch address.
REQ-006 InstrF  out  32  fetched word; valid when IReadyF=1.
REQ-007 IReadyF  out  1  one-cycle fetch-complete pulse.
REQ-008 DReqM  in  1  data-port request; held until DReadyM.
REQ-009 MemWriteM  in  1  data access is write (1) or read (0).
REQ-010 ALUOutM  in  32  data address.
REQ-011 WriteDataM  in  32  store data.
REQ-012 ReadDataM  out  32  load data; valid when DReadyM=1.
REQ-013 DReadyM  out  1  one-cycle data-complete pulse.
REQ-014 MemStall  out  1  pipeline stall; combinational.
REQ-015 MemReq, MemWe  out  1 each  memory request / write enable.
REQ-016 MemAddr, MemWData  out  32 each  memory address / write data.
REQ-017 MemRData  in  32; MemAck  in  1  memory read data / access done.
REQ-018 MemErr  out  1  sticky timeout error.

Function
REQ-019 FSM states IDLE, DATA, FETCH; single-ported memory shared by fetch and data ports.
REQ-020 IDLE: eligible DReqM -> DATA; else eligible IReqF -> FETCH; else stay. Data wins simultaneous requests.
REQ-021 A port is ineligible for grant in the cycle its own ready pulse is high (no duplicate access).
REQ-022 On grant, address, MemWe (=MemWriteM for data, 0 for fetch) and MemWData registered; held constant for whole access.
REQ-023 MemReq=1 exactly while in DATA or FETCH; 0 in IDLE.
REQ-024 DATA/FETCH with MemAck=1: next state IDLE; next cycle the matching ready pulses for 1 cycle.
REQ-025 Read data: MemRData captured into ReadDataM (DATA) or InstrF (FETCH) on ack edge; register held until next capture.
REQ-026 Writes: DReadyM pulses; ReadDataM unchanged.
REQ-027 Ready pulses only if the port's request is still high in the ack cycle; otherwise the access completes silently (flushed requester).
REQ-028 Minimum latency: request seen in IDLE cycle N, MemAck in N+1 -> ready in N+2.
REQ-029 4-bit wait counter cleared on grant, +1 per DATA/FETCH cycle without MemAck.
REQ-030 Counter reaching TIMEOUT without ack: abort -> IDLE, MemReq low next cycle, no ready pulse, MemErr=1.
REQ-031 MemErr sticky until reset; arbitration continues normally while set.
REQ-032 MemStall = (DReqM & ~DReadyM) | (IReqF & ~IReadyF).
REQ-033 MemAck in IDLE ignored.

Reset
REQ-034 reset=1 at edge: state IDLE, counter 0, MemReq/MemWe/IReadyF/DReadyM/MemErr 0, InstrF/ReadDataM/MemAddr/MemWData 0x00000000.
REQ-035 Reset mid-access abandons it: MemReq=0 from next cycle, no ready pulse, no capture.

Verification
REQ-036 IReqF=1, PCF=0x00000010, MemAck in first FETCH cycle, MemRData=0xE2811001 -> MemAddr=0x10, IReadyF at cycle N+2, InstrF=0xE2811001.
REQ-037 IReqF and DReqM both 1 (read, ALUOutM=0x80) -> DATA first (MemAddr=0x80), DReadyM pulse, then FETCH; exactly one access per port.
REQ-038 Store ALUOutM=0x40, WriteDataM=0x12345678, ack after 3 wait cycles -> MemWe=1, MemWData=0x12345678 held 4 cycles, DReadyM 1 cycle, ReadDataM unchanged.
REQ-039 TIMEOUT=4, MemAck never -> MemReq high 4 cycles then low, MemErr=1 persists, no ready; next IReqF still served.
REQ-040 Reset during FETCH wait -> MemReq=0 next cycle, IReadyF stays 0, all outputs at reset values.
